// File: rtl/demux1x8_framer_if.sv
// Purpose: bundles the TDM input word, its qualifiers and the eight demuxed channel outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the framer accepts a word on every cycle in_valid is high.
interface demux1x8_framer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] IN;
    logic             in_valid;
    logic             sof;
    logic [WIDTH-1:0] OUT1;
    logic [WIDTH-1:0] OUT2;
    logic [WIDTH-1:0] OUT3;
    logic [WIDTH-1:0] OUT4;
    logic [WIDTH-1:0] OUT5;
    logic [WIDTH-1:0] OUT6;
    logic [WIDTH-1:0] OUT7;
    logic [WIDTH-1:0] OUT8;
    logic [2:0]       slot;
    logic             frame_done;

    // Source of the TDM stream; observes the channels.
    modport master (
        output IN, in_valid, sof,
        input  OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, OUT7, OUT8, slot, frame_done
    );

    // The framer itself.
    modport slave (
        input  IN, in_valid, sof,
        output OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, OUT7, OUT8, slot, frame_done
    );
endinterface

// File: rtl/demux1x8_framer.sv
// Purpose: demultiplexes a TDM word stream into 8 registered channels; sof realigns to slot 0.
// Latency: a word shows on its OUTn one cycle after acceptance (FRAME_SHADOW_EN: all 8 at frame end).
// Backpressure: none; every in_valid word is accepted. Macro FRAME_SHADOW_EN selects shadowed update.
module demux1x8_framer #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    demux1x8_framer_if.slave    bus
);
    logic [2:0]       cnt;
    logic [2:0]       wr_slot;
    logic             done_q;
    logic [WIDTH-1:0] ch [8];

    // sof overrides the counter so the current word (if any) lands in slot 0.
    always_comb begin
        wr_slot = cnt;
        if (bus.sof) begin
            wr_slot = 3'd0;
        end
    end

    // Slot counter and frame-complete pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 3'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= bus.in_valid && (wr_slot == 3'd7);
            if (bus.in_valid) begin
                cnt <= wr_slot + 3'd1;
            end else if (bus.sof) begin
                cnt <= 3'd0;
            end
        end
    end

`ifdef FRAME_SHADOW_EN
    logic [WIDTH-1:0] shadow [8];

    // Collect words in shadow storage; publish all channels together when slot 7 is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                ch[i]     <= '0;
            end
        end else if (bus.in_valid) begin
            shadow[wr_slot] <= bus.IN;
            if (wr_slot == 3'd7) begin
                for (int i = 0; i < 7; i++) begin
                    ch[i] <= shadow[i];
                end
                ch[7] <= bus.IN;
            end
        end
    end
`else
    // Each accepted word goes straight into its channel register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                ch[i] <= '0;
            end
        end else if (bus.in_valid) begin
            ch[wr_slot] <= bus.IN;
        end
    end
`endif

    assign bus.slot       = cnt;
    assign bus.frame_done = done_q;
    assign bus.OUT1       = ch[0];
    assign bus.OUT2       = ch[1];
    assign bus.OUT3       = ch[2];
    assign bus.OUT4       = ch[3];
    assign bus.OUT5       = ch[4];
    assign bus.OUT6       = ch[5];
    assign bus.OUT7       = ch[6];
    assign bus.OUT8       = ch[7];
endmodule

// File: tb/tb_demux1x8_framer.sv
// Purpose: directed-vector bench; a scoreboard queue holds expected channel sets per frame_done.
// Latency: checks one-cycle write visibility and frame_done spacing.
// Backpressure: not applicable; stimulus drives in_valid freely.
module tb_demux1x8_framer;
    localparam int WIDTH = 4;

    typedef logic [7:0][WIDTH-1:0] chans_t;
    typedef struct packed {
        chans_t      w;
        logic [31:0] gap;
    } exp_t;

    logic clk;
    logic rst;
    demux1x8_framer_if #(.WIDTH(WIDTH)) bus ();

    demux1x8_framer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total;
    int   bad;
    int   frames_seen;
    int   cyc;
    int   last_fd_cyc;
    logic prev_fd;
    exp_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic chans_t outs();
        return {bus.OUT8, bus.OUT7, bus.OUT6, bus.OUT5, bus.OUT4, bus.OUT3, bus.OUT2, bus.OUT1};
    endfunction

    task automatic chk_outs(input string nm, input chans_t exp);
        chans_t act;
        act = outs();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s OUT%0d", nm, k + 1), 32'(act[k]), 32'(exp[k]));
        end
    endtask

    function automatic chans_t seq(input int start, input int step);
        chans_t v;
        for (int k = 0; k < 8; k++) begin
            v[k] = WIDTH'(start + step * k);
        end
        return v;
    endfunction

    task automatic send(input logic [WIDTH-1:0] w, input logic s);
        bus.IN       = w;
        bus.in_valid = 1'b1;
        bus.sof      = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input chans_t w, input int gap);
        exp_t e;
        e.w   = w;
        e.gap = 32'(gap);
        sb.push_back(e);
    endtask

    // Monitor: each frame_done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.frame_done) begin
            exp_t e;
            chk("frame_done width", 32'(prev_fd), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected frame_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk_outs("frame", e.w);
                if (e.gap != 0) begin
                    chk("frame_done spacing", 32'(cyc - last_fd_cyc), e.gap);
                end
            end
            frames_seen++;
            last_fd_cyc = cyc;
        end
        prev_fd = bus.frame_done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chans_t e;
        total        = 0;
        bad          = 0;
        frames_seen  = 0;
        cyc          = 0;
        last_fd_cyc  = 0;
        prev_fd      = 1'b0;
        rst          = 1'b1;
        bus.IN       = '0;
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;

        // Reset state.
        idle(3);
        chk("reset slot", 32'(bus.slot), 0);
        chk("reset frame_done", 32'(bus.frame_done), 0);
        chk_outs("reset", '0);
        rst = 1'b0;
        idle(1);

        // Clean frame 1..8, sof on the first word.
        push(seq(1, 1), 0);
        send(4'd1, 1'b1);
        for (int k = 2; k <= 8; k++) send(WIDTH'(k), 1'b0);
        idle(1);
        chk("after frame slot", 32'(bus.slot), 0);
        chk("after frame frame_done low", 32'(bus.frame_done), 0);

        // Back-to-back frames 1..8 then 8..1.
        push(seq(1, 1), 0);
        push(seq(8, -1), 8);
        send(4'd1, 1'b1);
        for (int k = 2; k <= 8; k++) send(WIDTH'(k), 1'b0);
        for (int k = 8; k >= 1; k--) send(WIDTH'(k), 1'b0);
        idle(1);
        chk("b2b OUT1", 32'(bus.OUT1), 8);
        chk("b2b OUT8", 32'(bus.OUT8), 1);

        // Frame 1..8 with idle gaps of 1..3 cycles; slot holds in gaps.
        push(seq(1, 1), 0);
        for (int k = 0; k < 8; k++) begin
            idle((k % 3) + 1);
            chk($sformatf("gap slot %0d", k), 32'(bus.slot), 32'(k));
            send(WIDTH'(k + 1), k == 0);
        end
        idle(1);

        // Abandoned frame: 1,2,3 then sof with 9.
        send(4'd1, 1'b1);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        send(4'd9, 1'b1);
        chk("sof realign slot", 32'(bus.slot), 1);
`ifdef FRAME_SHADOW_EN
        chk("sof realign OUT1", 32'(bus.OUT1), 1);
`else
        chk("sof realign OUT1", 32'(bus.OUT1), 9);
`endif
        // sof without a word only clears the counter.
        bus.sof = 1'b1;
        idle(1);
        bus.sof = 1'b0;
        chk("sof-only slot", 32'(bus.slot), 0);
`ifdef FRAME_SHADOW_EN
        chk("sof-only OUT1", 32'(bus.OUT1), 1);
`else
        chk("sof-only OUT1", 32'(bus.OUT1), 9);
`endif

        // Frame 1..8 then 15,15,15 into the next frame.
        push(seq(1, 1), 0);
        send(4'd1, 1'b1);
        for (int k = 2; k <= 8; k++) send(WIDTH'(k), 1'b0);
        for (int k = 0; k < 3; k++) send(4'd15, 1'b0);
        e = seq(1, 1);
`ifndef FRAME_SHADOW_EN
        e[0] = 4'd15;
        e[1] = 4'd15;
        e[2] = 4'd15;
`endif
        chk_outs("partial", e);
        chk("partial slot", 32'(bus.slot), 3);

        // Asynchronous reset mid-frame after 5 words.
        send(4'd1, 1'b1);
        for (int k = 2; k <= 5; k++) send(WIDTH'(k), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst slot", 32'(bus.slot), 0);
        chk("async rst frame_done", 32'(bus.frame_done), 0);
        chk_outs("async rst", '0);
        bus.IN       = 4'd5;
        bus.in_valid = 1'b1;
        bus.sof      = 1'b1;
        idle(1);
        chk("rst ignores in_valid slot", 32'(bus.slot), 0);
        chk("rst ignores in_valid OUT1", 32'(bus.OUT1), 0);
        bus.in_valid = 1'b0;
        bus.sof      = 1'b0;
        rst          = 1'b0;
        idle(1);
        send(4'd7, 1'b0);
        chk("post rst slot", 32'(bus.slot), 1);
`ifdef FRAME_SHADOW_EN
        chk("post rst OUT1", 32'(bus.OUT1), 0);
`else
        chk("post rst OUT1", 32'(bus.OUT1), 7);
`endif

        idle(2);
        chk("scoreboard drained", 32'(sb.size()), 0);
        chk("frames seen", 32'(frames_seen), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
